// File: rtl/fmul_mant_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fmul_mant_sched
//  Description : Two-port scheduler for a shared, fixed-latency mantissa
//                multiplier. Round-robin arbitration between the two request
//                ports is combinational. The winning operand pair is
//                registered onto mul_a/mul_b with a one-cycle issue strobe.
//                A LAT-deep tag pipeline follows each issued operation through
//                the multiplier, so every product is routed back to the port
//                that requested it.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    W    mantissa operand width (product is 2*W)
//    LAT  multiplier latency in cycles, 1..8
//  Ports
//    clk, rst                       clock, asynchronous active-high reset
//    req{0,1}_valid/_a/_b/_ready    request ports (transfer on valid & ready)
//    mul_issue, mul_a, mul_b        registered operands to the multiplier
//    mul_p                          product, valid LAT cycles after mul_issue
//    rsp0_valid, rsp1_valid, rsp_p  registered per-port result strobe, product
//    busy                           an operation is issued or in flight
// ============================================================================
module fmul_mant_sched #(
  parameter int W   = 24,
  parameter int LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           mul_issue,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [2*W-1:0] rsp_p,
  output logic           busy
);

  // last_grant records the port that won the most recent transfer. It resets
  // to 1 so that port 0 wins the first tie after reset.
  logic           last_grant;
  logic           grant0;
  logic           grant1;
  logic           issue_port;

  // Tag pipeline: bit i is the tag i+1 cycles after its issue cycle. The tag
  // leaves stage LAT-1 in exactly the cycle the product is on mul_p.
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_p;
  logic [LAT-1:0] tag_v_nxt;
  logic [LAT-1:0] tag_p_nxt;

  // --------------------------------------------------------------------------
  // Arbitration. Grants are masked while reset is asserted, so no transfer can
  // be seen by a requester during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // --------------------------------------------------------------------------
  // Tag shift. A single-stage pipeline has no lower bits to shift up.
  // --------------------------------------------------------------------------
  generate
    if (LAT == 1) begin : g_tag_single
      assign tag_v_nxt = mul_issue;
      assign tag_p_nxt = issue_port;
    end else begin : g_tag_chain
      assign tag_v_nxt = {tag_v[LAT-2:0], mul_issue};
      assign tag_p_nxt = {tag_p[LAT-2:0], issue_port};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Issue register, tag pipeline and response register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      mul_issue  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      issue_port <= 1'b0;
      tag_v      <= '0;
      tag_p      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_p      <= '0;
    end else begin
      mul_issue <= grant0 | grant1;
      // Operands hold their previous values when nothing is issued.
      if (grant0) begin
        mul_a      <= req0_a;
        mul_b      <= req0_b;
        issue_port <= 1'b0;
        last_grant <= 1'b0;
      end else if (grant1) begin
        mul_a      <= req1_a;
        mul_b      <= req1_b;
        issue_port <= 1'b1;
        last_grant <= 1'b1;
      end

      tag_v <= tag_v_nxt;
      tag_p <= tag_p_nxt;

      // Exiting tag steers the product to its port; rsp_p otherwise holds.
      rsp0_valid <= tag_v[LAT-1] & ~tag_p[LAT-1];
      rsp1_valid <= tag_v[LAT-1] &  tag_p[LAT-1];
      if (tag_v[LAT-1]) begin
        rsp_p <= mul_p;
      end
    end
  end

  assign busy = mul_issue | (|tag_v) | rsp0_valid | rsp1_valid;

endmodule
`default_nettype wire

// File: tb/tb_fmul_mant_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmul_mant_sched
//  Description : Self-checking bench for fmul_mant_sched (W=24, LAT=3).
//                The multiplier is modelled as an ideal LAT-cycle pipe driving
//                random data on mul_p in every cycle it is not due. A queue of
//                accepted operations predicts readies, issues, responses and
//                busy on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fmul_mant_sched;

  localparam int W   = 24;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid = 1'b0;
  logic [W-1:0]   req0_a = '0;
  logic [W-1:0]   req0_b = '0;
  logic           req0_ready;
  logic           req1_valid = 1'b0;
  logic [W-1:0]   req1_a = '0;
  logic [W-1:0]   req1_b = '0;
  logic           req1_ready;
  logic           mul_issue;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_p = '0;
  logic           rsp0_valid;
  logic           rsp1_valid;
  logic [2*W-1:0] rsp_p;
  logic           busy;

  fmul_mant_sched #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_issue(mul_issue), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] mulw(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] x;
    x = {{W{1'b0}}, a};
    return x * {{W{1'b0}}, b};
  endfunction

  // --------------------------------------------------------------------------
  // Multiplier environment: product due exactly LAT cycles after the issue.
  // --------------------------------------------------------------------------
  logic [2*W-1:0] prod_at [int];

  always @(posedge clk) begin
    #1;
    if (prod_at.exists(cyc)) mul_p = prod_at[cyc];
    else mul_p = {$urandom, $urandom};
  end

  // --------------------------------------------------------------------------
  // Reference model: every accepted op answers LAT+2 cycles later, in order.
  // --------------------------------------------------------------------------
  typedef struct {
    int             acc;
    int             due;
    bit             port;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } op_t;

  op_t            pend[$];
  op_t            op;
  bit             last_g = 1'b1;
  logic [W-1:0]   ha = '0;
  logic [W-1:0]   hb = '0;
  logic [2*W-1:0] hp = '0;
  bit             e0, e1, ei, er0, er1;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_issue", mul_issue, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_rsp0", rsp0_valid, 0);
      chk("rst_rsp1", rsp1_valid, 0);
      chk("rst_rsp_p", rsp_p, 0);
      chk("rst_busy", busy, 0);
      pend.delete();
      prod_at.delete();
      last_g = 1'b1;
      ha = '0;
      hb = '0;
      hp = '0;
    end else begin
      // round-robin: lone requester wins, a tie goes to the port not granted last
      e0 = req0_valid && (!req1_valid || last_g == 1'b1);
      e1 = req1_valid && !e0;
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);

      ei = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].acc == cyc - 1) begin
          ei = 1'b1;
          ha = pend[i].a;
          hb = pend[i].b;
        end
      end
      chk("mul_issue", mul_issue, ei);
      chk("mul_a", mul_a, ha);
      chk("mul_b", mul_b, hb);
      if (mul_issue) prod_at[cyc + LAT] = mulw(mul_a, mul_b);

      chk("busy", busy, pend.size() != 0);

      er0 = 1'b0;
      er1 = 1'b0;
      if (pend.size() != 0 && pend[0].due == cyc) begin
        op = pend.pop_front();
        er0 = (op.port == 1'b0);
        er1 = (op.port == 1'b1);
        hp  = op.prod;
      end
      chk("rsp0_valid", rsp0_valid, er0);
      chk("rsp1_valid", rsp1_valid, er1);
      chk("rsp_p", rsp_p, hp);

      if (e0 || e1) begin
        op.acc  = cyc;
        op.due  = cyc + LAT + 2;
        op.port = e1;
        op.a    = e1 ? req1_a : req0_a;
        op.b    = e1 ? req1_b : req0_b;
        op.prod = mulw(op.a, op.b);
        pend.push_back(op);
        last_g = e1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic drive(input bit r, input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    @(posedge clk);
    #1;
    rst = r;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic pulse_reset();
    drive(1, 0, '0, '0, 0, '0, '0);
    drive(1, 0, '0, '0, 0, '0, '0);
    drive(0, 0, '0, '0, 0, '0, '0);
  endtask

  logic [W-1:0] ra, rb, rc, rd;
  int           n1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pulse_reset();
    idle(2);

    // Single op with known operands and product.
    drive(0, 1, 24'h800000, 24'hC00000, 0, '0, '0);
    @(negedge clk);
    chk("single_ready0", req0_ready, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, '0, '0, 0, '0, '0);
    @(negedge clk);
    chk("single_rsp0", rsp0_valid, 1);
    chk("single_rsp_p", rsp_p, 48'h600000000000);

    // Idle after a completed op: everything holds, nothing strobes.
    idle(20);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_p", rsp_p, 48'h600000000000);
    chk("idle_mul_a", mul_a, 24'h800000);

    // Contention right after reset: grants alternate 0,1,0,1.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 24'h100000 + 24'(i), 24'h000003, 1, 24'h200000 + 24'(i), 24'h000005);
      @(negedge clk);
      chk("tie_ready0", req0_ready, (i % 2) == 0);
      chk("tie_ready1", req1_ready, (i % 2) == 1);
    end
    idle(8);

    // Port 1 streaming: ready every cycle, six back-to-back responses.
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, '0, '0, 1, 24'($urandom), 24'($urandom));
      @(negedge clk);
      chk("stream_ready1", req1_ready, 1);
      if (rsp1_valid) n1++;
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, '0, '0, 0, '0, '0);
      @(negedge clk);
      if (rsp1_valid) n1++;
    end
    chk("stream_count", n1, 6);

    // Reset mid-flight: in-flight ops must vanish.
    for (int i = 0; i < 3; i++) drive(0, 1, 24'($urandom), 24'($urandom), 0, '0, '0);
    pulse_reset();
    idle(8);
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_rsp_p", rsp_p, 0);

    // Pointer hold: port 1 alone, idle, then a tie goes to port 0.
    drive(0, 0, '0, '0, 1, 24'h000011, 24'h000022);
    idle(5);
    drive(0, 1, 24'h000033, 24'h000044, 1, 24'h000055, 24'h000066);
    @(negedge clk);
    chk("hold_ready0", req0_ready, 1);
    chk("hold_ready1", req1_ready, 0);
    idle(8);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      ra = 24'($urandom); rb = 24'($urandom); rc = 24'($urandom); rd = 24'($urandom);
      if (i == 200) pulse_reset();
      drive(0, $urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0, rc, rd);
    end
    idle(LAT + 4);
    @(negedge clk);
    chk("drain_empty", pend.size(), 0);
    chk("drain_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fmul_mant_sched.md
FMUL_MANT_SCHED -- requirements
Module: fmul_mant_sched

Interface
REQ-001 Parameter W, default 24, mantissa operand width in bits.
REQ-002 Parameter LAT, default 3, fixed latency in cycles of the shared mantissa multiplier; legal range 1..8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high; clears all state immediately.
REQ-005 req0_valid  input  1  port 0 has an operand pair.
REQ-006 req0_a, req0_b  input  W each  port 0 mantissa operands.
REQ-007 req0_ready  output  1  port 0 granted this cycle; transfer when valid & ready.
REQ-008 req1_valid, req1_a, req1_b, req1_ready  same as port 0, for port 1.
REQ-009 mul_issue  output  1  registered strobe: operands on mul_a/mul_b are valid this cycle.
REQ-010 mul_a, mul_b  output  W each  registered operands to the shared multiplier.
REQ-011 mul_p  input  2W  multiplier product, valid exactly LAT cycles after the matching mul_issue cycle.
REQ-012 rsp0_valid, rsp1_valid  output  1 each  registered one-cycle result strobe per port.
REQ-013 rsp_p  output  2W  registered product, shared by both ports.
REQ-014 busy  output  1  any operation issued or in flight.

Function
REQ-015 The block SHALL assert at most one of req0_ready/req1_ready per cycle; ready is combinational from valids and the priority pointer.
REQ-016 The block SHALL grant the only valid port when one requests.
REQ-017 The block SHALL grant the port not granted last when both request.
REQ-018 The priority pointer SHALL update only on a transfer, to the granted port.
REQ-019 The block SHALL never assert ready for a port whose valid is low.
REQ-020 A transfer in cycle T SHALL produce mul_issue=1 in T+1 with mul_a/mul_b equal to that port's operands.
REQ-021 mul_a/mul_b SHALL hold their last values in cycles with mul_issue=0.
REQ-022 Each issue SHALL push a tag (valid bit, port id) into a LAT-deep shift register advancing every cycle.
REQ-023 When the tag exits (cycle T+1+LAT), the block SHALL register mul_p into rsp_p and pulse the tagged port's rsp valid in T+2+LAT.
REQ-024 Total accept-to-response latency SHALL be LAT+2 cycles; throughput one operation per cycle, back-to-back, no bubbles.
REQ-025 Responses SHALL return in issue order; rsp0_valid and rsp1_valid SHALL never be high together.
REQ-026 rsp_p SHALL hold its value when no response strobe is active.
REQ-027 Responses have no backpressure; requesters SHALL accept every strobe.
REQ-028 busy SHALL be high in any cycle where mul_issue, any tag valid bit, or a response strobe is high.
REQ-029 A transfer in the same cycle a response is delivered SHALL be handled independently, with no stall.

Reset
REQ-030 On rst high, all outputs SHALL be 0: mul_issue, mul_a, mul_b, rsp0_valid, rsp1_valid, rsp_p, busy. The priority pointer SHALL reset so port 0 wins the first tie.
REQ-031 rst mid-operation SHALL drop all in-flight tags; no response SHALL appear for any operation accepted before reset.
REQ-032 While rst is high, req0_ready and req1_ready SHALL be 0.

Verification (LAT=3)
REQ-033 Single op: port 0 sends a=0x800000, b=0xC00000 in cycle 0 -> mul_issue in cycle 1; with the model returning 0x600000000000 in cycle 4, rsp0_valid=1 and rsp_p=0x600000000000 in cycle 5.
REQ-034 Contention: both ports valid continuously for 4 cycles after reset -> grants 0,1,0,1; responses alternate rsp0/rsp1 in cycles 5..8, each product matched to its own operands.
REQ-035 Single requester streaming: port 1 valid for 6 cycles -> ready high all 6 cycles; 6 consecutive rsp1_valid pulses with no gaps.
REQ-036 Reset mid-flight: 3 ops accepted in cycles 0..2, rst pulsed in cycle 3 -> no rsp strobes afterwards; all outputs 0; busy=0.
REQ-037 Idle: no valids for 20 cycles after one completed op -> busy=0; mul_a/mul_b/rsp_p hold their last values; no strobes.
REQ-038 Pointer hold: port 1 granted alone, then idle 5 cycles, then both valid -> port 0 granted first.
